// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and constants for the pipeline stall controller
package pipeline_ctrl_pkg;

    // Memory-stall sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MISS   = 2'd1,
        RESUME = 2'd2
    } stall_state_t;

    // result_src encoding that marks a load in the execute stage
    localparam logic [2:0] RESULT_SRC_LOAD = 3'b001;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with asynchronous active-low clear
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    // Count enabled cycles, holding at all-ones instead of wrapping
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_count <= '0;
        end else if (i_en && (o_count != '1)) begin
            o_count <= o_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - stall/flush control for cache misses, load-use hazards and taken branches
module pipeline_stall_ctrl #(
    parameter int         REG_ADDR_W      = 5,
    parameter int         CNT_W           = 32,
    parameter logic [2:0] RESULT_SRC_LOAD = pipeline_ctrl_pkg::RESULT_SRC_LOAD
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_mem_access_m,
    input  logic                  i_cache_hit,
    input  logic                  i_cache_done,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr_d,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr_d,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_e,
    input  logic [2:0]            i_result_src_e,
    input  logic                  i_branch_taken_e,
    output logic                  o_stall_f,
    output logic                  o_stall_d,
    output logic                  o_stall_e,
    output logic                  o_stall_mem,
    output logic                  o_flush_d,
    output logic                  o_flush_e,
    output logic [CNT_W-1:0]      o_miss_cnt,
    output logic [CNT_W-1:0]      o_stall_cyc_cnt
);

    import pipeline_ctrl_pkg::*;

    stall_state_t state;
    logic         miss_detect;
    logic         stall_mem_raw;
    logic         load_use;

    // A miss is only recognised from IDLE; in MISS/RESUME the stall is already held
    assign miss_detect   = (state == IDLE) && i_mem_access_m && !i_cache_hit;
    assign stall_mem_raw = (state != IDLE) || miss_detect;

    assign load_use = (i_result_src_e == RESULT_SRC_LOAD) &&
                      (i_rd_addr_e != '0) &&
                      ((i_rd_addr_e == i_rs1_addr_d) || (i_rd_addr_e == i_rs2_addr_d));

    // Miss sequencer: wait in MISS for the refill pulse, then one RESUME cycle
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (miss_detect) state <= MISS;
                MISS:    if (i_cache_done) state <= RESUME;
                RESUME:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Priority: reset forces quiet, memory stall freezes everything, branch beats load-use
    always_comb begin
        o_stall_f   = 1'b0;
        o_stall_d   = 1'b0;
        o_stall_e   = 1'b0;
        o_stall_mem = 1'b0;
        o_flush_d   = 1'b0;
        o_flush_e   = 1'b0;
        if (!i_arst_n) begin
            o_stall_mem = 1'b0;
        end else if (stall_mem_raw) begin
            o_stall_f   = 1'b1;
            o_stall_d   = 1'b1;
            o_stall_e   = 1'b1;
            o_stall_mem = 1'b1;
        end else if (i_branch_taken_e) begin
            o_flush_d = 1'b1;
            o_flush_e = 1'b1;
        end else if (load_use) begin
            o_stall_f = 1'b1;
            o_stall_d = 1'b1;
            o_flush_e = 1'b1;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_miss_cnt (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_en     (miss_detect),
        .o_count  (o_miss_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_stall_cyc_cnt (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_en     (o_stall_mem),
        .o_count  (o_stall_cyc_cnt)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - scoreboard bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

    logic       i_clk = 1'b0;
    logic       i_arst_n = 1'b0;
    logic       i_mem_access_m = 1'b0;
    logic       i_cache_hit = 1'b0;
    logic       i_cache_done = 1'b0;
    logic [4:0] i_rs1_addr_d = '0;
    logic [4:0] i_rs2_addr_d = '0;
    logic [4:0] i_rd_addr_e = '0;
    logic [2:0] i_result_src_e = '0;
    logic       i_branch_taken_e = 1'b0;

    logic        stall_f, stall_d, stall_e, stall_mem, flush_d, flush_e;
    logic [31:0] miss_cnt, cyc_cnt;
    logic        s4_f, s4_d, s4_e, s4_mem, f4_d, f4_e;
    logic [3:0]  miss_cnt4, cyc_cnt4;

    always #5 i_clk = ~i_clk;

    pipeline_stall_ctrl dut (
        .i_clk            (i_clk),
        .i_arst_n         (i_arst_n),
        .i_mem_access_m   (i_mem_access_m),
        .i_cache_hit      (i_cache_hit),
        .i_cache_done     (i_cache_done),
        .i_rs1_addr_d     (i_rs1_addr_d),
        .i_rs2_addr_d     (i_rs2_addr_d),
        .i_rd_addr_e      (i_rd_addr_e),
        .i_result_src_e   (i_result_src_e),
        .i_branch_taken_e (i_branch_taken_e),
        .o_stall_f        (stall_f),
        .o_stall_d        (stall_d),
        .o_stall_e        (stall_e),
        .o_stall_mem      (stall_mem),
        .o_flush_d        (flush_d),
        .o_flush_e        (flush_e),
        .o_miss_cnt       (miss_cnt),
        .o_stall_cyc_cnt  (cyc_cnt)
    );

    pipeline_stall_ctrl #(.CNT_W(4)) dut4 (
        .i_clk            (i_clk),
        .i_arst_n         (i_arst_n),
        .i_mem_access_m   (i_mem_access_m),
        .i_cache_hit      (i_cache_hit),
        .i_cache_done     (i_cache_done),
        .i_rs1_addr_d     (i_rs1_addr_d),
        .i_rs2_addr_d     (i_rs2_addr_d),
        .i_rd_addr_e      (i_rd_addr_e),
        .i_result_src_e   (i_result_src_e),
        .i_branch_taken_e (i_branch_taken_e),
        .o_stall_f        (s4_f),
        .o_stall_d        (s4_d),
        .o_stall_e        (s4_e),
        .o_stall_mem      (s4_mem),
        .o_flush_d        (f4_d),
        .o_flush_e        (f4_e),
        .o_miss_cnt       (miss_cnt4),
        .o_stall_cyc_cnt  (cyc_cnt4)
    );

    typedef struct {
        logic [5:0]  ctl;
        logic [31:0] miss;
        logic [31:0] cyc;
        logic [3:0]  miss4;
        logic [3:0]  cyc4;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a pending-miss flag, a one-shot resume flag and plain integer tallies
    bit m_in_miss = 1'b0;
    bit m_resume  = 1'b0;
    int m_miss    = 0;
    int m_cyc     = 0;

    function automatic logic [3:0] sat4(input int v);
        return (v > 15) ? 4'd15 : 4'(v);
    endfunction

    task automatic drive(input logic rst_n, input logic ma, input logic hit, input logic done,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [2:0] src, input logic br);
        exp_t e;
        bit   idle, new_miss, smem, lu;
        logic sf, sd, se, fd, fe;
        @(negedge i_clk);
        i_arst_n = rst_n; i_mem_access_m = ma; i_cache_hit = hit; i_cache_done = done;
        i_rs1_addr_d = rs1; i_rs2_addr_d = rs2; i_rd_addr_e = rd;
        i_result_src_e = src; i_branch_taken_e = br;
        if (!rst_n) begin
            m_in_miss = 1'b0; m_resume = 1'b0; m_miss = 0; m_cyc = 0;
            e.ctl = 6'b0; e.miss = 0; e.cyc = 0; e.miss4 = 0; e.cyc4 = 0;
        end else begin
            idle     = !m_in_miss && !m_resume;
            new_miss = idle && ma && !hit;
            smem     = !idle || new_miss;
            lu       = (src == 3'b001) && (rd != 0) && (rd == rs1 || rd == rs2);
            {sf, sd, se, fd, fe} = 5'b0;
            if (smem) begin
                sf = 1; sd = 1; se = 1;
            end else if (br) begin
                fd = 1; fe = 1;
            end else if (lu) begin
                sf = 1; sd = 1; fe = 1;
            end
            e.ctl   = {sf, sd, se, smem, fd, fe};
            e.miss  = 32'(m_miss);
            e.cyc   = 32'(m_cyc);
            e.miss4 = sat4(m_miss);
            e.cyc4  = sat4(m_cyc);
            if (new_miss) m_miss++;
            if (smem) m_cyc++;
            if (m_resume) m_resume = 1'b0;
            else if (m_in_miss && done) begin m_in_miss = 1'b0; m_resume = 1'b1; end
            else if (new_miss) m_in_miss = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle_cyc(input int n);
        for (int k = 0; k < n; k++) drive(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 3'd0, 0);
    endtask

    // Monitor: pop one expectation per cycle and compare in the low clock phase
    initial begin
        exp_t  e;
        logic [5:0] act;
        forever begin
            @(negedge i_clk);
            #2;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {stall_f, stall_d, stall_e, stall_mem, flush_d, flush_e};
                checks++;
                if (act !== e.ctl) begin
                    errors++;
                    $display("FAIL ctl t=%0t actual=%b required=%b", $time, act, e.ctl);
                end
                checks++;
                if ({s4_f, s4_d, s4_e, s4_mem, f4_d, f4_e} !== e.ctl) begin
                    errors++;
                    $display("FAIL ctl4 t=%0t actual=%b required=%b", $time,
                             {s4_f, s4_d, s4_e, s4_mem, f4_d, f4_e}, e.ctl);
                end
                checks++;
                if (miss_cnt !== e.miss) begin
                    errors++;
                    $display("FAIL miss_cnt t=%0t actual=%0d required=%0d", $time, miss_cnt, e.miss);
                end
                checks++;
                if (cyc_cnt !== e.cyc) begin
                    errors++;
                    $display("FAIL stall_cyc_cnt t=%0t actual=%0d required=%0d", $time, cyc_cnt, e.cyc);
                end
                checks++;
                if (miss_cnt4 !== e.miss4) begin
                    errors++;
                    $display("FAIL miss_cnt4 t=%0t actual=%0d required=%0d", $time, miss_cnt4, e.miss4);
                end
                checks++;
                if (cyc_cnt4 !== e.cyc4) begin
                    errors++;
                    $display("FAIL stall_cyc_cnt4 t=%0t actual=%0d required=%0d", $time, cyc_cnt4, e.cyc4);
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by random traffic
    initial begin
        drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 3'd0, 0);
        drive(0, 1, 0, 0, 5'd5, 5'd0, 5'd5, 3'd1, 1);
        idle_cyc(1);
        // load-use, then the same with rd=0
        drive(1, 0, 1, 0, 5'd5, 5'd0, 5'd5, 3'd1, 0);
        drive(1, 0, 1, 0, 5'd5, 5'd0, 5'd0, 3'd1, 0);
        drive(1, 0, 1, 0, 5'd0, 5'd9, 5'd9, 3'd1, 0);
        drive(1, 0, 1, 0, 5'd9, 5'd0, 5'd9, 3'd2, 0);
        // stray refill pulse in IDLE
        drive(1, 0, 1, 1, 5'd0, 5'd0, 5'd0, 3'd0, 0);
        // miss at cycle 0, refill done at cycle 10
        drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 3'd0, 0);
        idle_cyc(9);
        drive(1, 0, 1, 1, 5'd0, 5'd0, 5'd0, 3'd0, 0);
        idle_cyc(2);
        // branch with concurrent load-use
        drive(1, 0, 1, 0, 5'd3, 5'd7, 5'd7, 3'd1, 1);
        // branch held across a miss and its resume cycle
        drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 3'd0, 1);
        for (int k = 0; k < 3; k++) drive(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 3'd0, 1);
        drive(1, 0, 1, 1, 5'd0, 5'd0, 5'd0, 3'd0, 1);
        drive(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 3'd0, 1);
        drive(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 3'd0, 1);
        // reset at cycle 4 of a miss
        drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 3'd0, 0);
        idle_cyc(3);
        drive(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 3'd0, 1);
        drive(0, 0, 1, 1, 5'd2, 5'd0, 5'd2, 3'd1, 0);
        idle_cyc(2);
        // 20 back-to-back misses
        for (int k = 0; k < 20; k++) begin
            drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 3'd0, 0);
            drive(1, 1, 0, 1, 5'd0, 5'd0, 5'd0, 3'd0, 0);
            drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 3'd0, 0);
        end
        idle_cyc(2);
        // random traffic with small register indices to provoke hazards
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 5) == 0),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 0) ? 3'd1 : 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) == 0));
        end
        idle_cyc(1);
        repeat (3) @(negedge i_clk);
        #4;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
